// File: rtl/fcmp_sched_if.sv
// fcmp_sched_if
//  Bundles the requester-side and response-side signals of the shared
//  float-compare scheduler.
//  Ports (all logic):
//    req_valid  [NREQ]        request i valid
//    req_ready  [NREQ]        request i accepted this cycle (one-hot or zero)
//    req_op     [2*NREQ]      op of request i (00 FEQ, 01 FLT, 10 FLE, 11 reserved)
//    req_x1     [32*NREQ]     operand 1 of request i
//    req_x2     [32*NREQ]     operand 2 of request i
//    req_tag    [TAG_W*NREQ]  tag of request i
//    resp_valid               result valid
//    resp_ready               consumer accepts result
//    resp_id    [ID_W]        requester index that issued the result
//    resp_tag   [TAG_W]       echoed tag
//    resp_y     [32]          {31'b0, result}
//  master = issue logic / consumer side, slave = the scheduler.
interface fcmp_sched_if #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [32*NREQ-1:0]    req_x1;
  logic [32*NREQ-1:0]    req_x2;
  logic [TAG_W*NREQ-1:0] req_tag;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [TAG_W-1:0]      resp_tag;
  logic [31:0]           resp_y;

  modport master (
    output req_valid, req_op, req_x1, req_x2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_tag, resp_y
  );

  modport slave (
    input  req_valid, req_op, req_x1, req_x2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_id, resp_tag, resp_y
  );
endinterface

// File: rtl/fcmp_sched.sv
// fcmp_sched
//  Shared float-compare unit behind a round-robin scheduler. One requester is
//  granted per cycle; granted ops pass through an issue register (S1) and an
//  output register (S2) and come back in grant order on a single
//  backpressurable response port.
//  Ports:
//    clk  in  clock, all state on posedge
//    rst  in  asynchronous, active-high reset
//    bus  fcmp_sched_if.slave (request vectors, response channel)
module fcmp_sched #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  fcmp_sched_if.slave bus
);
  localparam int ID_W = $clog2(NREQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

  // S1 issue register
  logic             s1_v;
  logic [1:0]       s1_op;
  logic [31:0]      s1_x1;
  logic [31:0]      s1_x2;
  logic [TAG_W-1:0] s1_tag;
  logic [ID_W-1:0]  s1_id;

  // S2 occupancy; the resp_* registers hold its payload
  logic             s2_v;
  logic [ID_W-1:0]  rr_ptr;

  logic             adv1;
  logic             adv2;
  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  logic             accept;
  logic [1:0]       sel_op;
  logic [31:0]      sel_x1;
  logic [31:0]      sel_x2;
  logic [TAG_W-1:0] sel_tag;
  logic             cmp_res;

  // Maps an IEEE single onto an unsigned key whose natural order matches the
  // float order. Zero exponent (zeros and denormals) collapses to one key so
  // signed zeros compare equal; negatives are bit-inverted so larger
  // magnitudes sort lower.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    if (x[30:23] == 8'd0)
      return 32'h8000_0000;
    else if (!x[31])
      return {1'b1, x[30:0]};
    else
      return {1'b0, ~x[30:0]};
  endfunction

  // S2 drains when the consumer takes it; S1 can move into an empty or
  // draining S2; the issue slot is free whenever S1 is empty or moving.
  assign adv2   = s1_v & (~s2_v | bus.resp_ready);
  assign adv1   = ~s1_v | adv2;
  assign accept = adv1 & gnt_found;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Ready is only offered to the winner, and only when S1 can take it.
  always_comb begin
    bus.req_ready = '0;
    if (accept)
      bus.req_ready[gnt_idx] = 1'b1;
  end

  // Select the winning requester's payload.
  always_comb begin
    sel_op  = '0;
    sel_x1  = '0;
    sel_x2  = '0;
    sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_op  = bus.req_op[2*i +: 2];
        sel_x1  = bus.req_x1[32*i +: 32];
        sel_x2  = bus.req_x2[32*i +: 32];
        sel_tag = bus.req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  // Compare the S1 operands; reserved op always yields 0.
  always_comb begin
    logic [31:0] k1;
    logic [31:0] k2;
    k1 = order_key(s1_x1);
    k2 = order_key(s1_x2);
    cmp_res = 1'b0;
    case (s1_op)
      2'b00:   cmp_res = (k1 == k2);
      2'b01:   cmp_res = (k1 < k2);
      2'b10:   cmp_res = (k1 <= k2);
      default: cmp_res = 1'b0;
    endcase
  end

  // S1 register and arbitration pointer. The pointer only moves on an
  // accepted grant so a stalled winner keeps its turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_op  <= '0;
      s1_x1  <= '0;
      s1_x2  <= '0;
      s1_tag <= '0;
      s1_id  <= '0;
      rr_ptr <= LAST_ID;
    end else if (adv1) begin
      s1_v <= accept;
      if (accept) begin
        s1_op  <= sel_op;
        s1_x1  <= sel_x1;
        s1_x2  <= sel_x2;
        s1_tag <= sel_tag;
        s1_id  <= gnt_idx;
        rr_ptr <= gnt_idx;
      end
    end
  end

  // S2 output register; payload only changes when a new result moves in,
  // so it stays stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v         <= 1'b0;
      bus.resp_y   <= '0;
      bus.resp_tag <= '0;
      bus.resp_id  <= '0;
    end else if (adv2) begin
      s2_v         <= 1'b1;
      bus.resp_y   <= {31'b0, cmp_res};
      bus.resp_tag <= s1_tag;
      bus.resp_id  <= s1_id;
    end else if (bus.resp_ready) begin
      s2_v <= 1'b0;
    end
  end

  assign bus.resp_valid = s2_v;
endmodule
